// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default latencies and the out-of-range fill word.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } dmem_state_e;

  localparam int ADDR_W         = 26;
  localparam int DATA_W         = 32;
  localparam int BE_W           = 4;
  localparam int CNT_W          = 4;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_READ_LAT   = 4;
  localparam int DEF_WRITE_LAT  = 2;

  localparam logic [DATA_W-1:0] FILL_PATTERN = 32'hDEADBEEF;

  // Counter load for a latency of `lat` cycles; zero latency never waits.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return (lat == 0) ? '0 : CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port byte-enabled word RAM with a registered read port.
// Contents are deliberately not reset.
import dmem_pkg::*;

module dmem_bank #(
  parameter int AW = DEF_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for a cache master: fixed-latency reads and writes
// with waitrequest back-pressure and a sticky protocol/range error flag.
import dmem_pkg::*;

module dmem_responder #(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int READ_LAT   = DEF_READ_LAT,
  parameter int WRITE_LAT  = DEF_WRITE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_m_addr,
  input  logic [BE_W-1:0]   i_m_byte_en,
  input  logic [DATA_W-1:0] i_m_writedata,
  input  logic              i_m_read,
  input  logic              i_m_write,
  output logic [DATA_W-1:0] o_m_readdata,
  output logic              o_m_readdata_valid,
  output logic              o_m_waitrequest,
  output logic              o_err
);

  // state   | meaning
  // IDLE    | ready; a command present on this edge is accepted
  // RD_WAIT | read in flight, counting down to the data-valid pulse
  // WR_WAIT | write committed, holding waitrequest for the write latency

  localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LAT);

  dmem_state_e            state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [DEPTH_LOG2-1:0]  addr_q;
  logic                   oor_q;
  logic                   idle;
  logic                   accept_rd;
  logic                   accept_wr;
  logic                   addr_oor;
  logic                   rd_done;
  logic                   bank_we;
  logic [DEPTH_LOG2-1:0]  bank_addr;
  logic [DATA_W-1:0]      bank_rdata;

  assign idle      = (state == IDLE);
  // A simultaneous read+write is treated as a write; the read is dropped.
  assign accept_wr = idle && i_m_write;
  assign accept_rd = idle && i_m_read && !i_m_write;
  assign addr_oor  = |(i_m_addr >> DEPTH_LOG2);
  assign rd_done   = (state == RD_WAIT) && (cnt == '0);

  assign bank_we   = accept_wr && !addr_oor;
  // Present the live address while idle so READ_LAT=1 still has a registered read ready.
  assign bank_addr = idle ? i_m_addr[DEPTH_LOG2-1:0] : addr_q;

  dmem_bank #(
    .AW (DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (i_m_byte_en),
    .addr  (bank_addr),
    .wdata (i_m_writedata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_wr) begin
          state_nxt = (WRITE_LAT == 0) ? IDLE : WR_WAIT;
        end else if (accept_rd) begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_m_waitrequest = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept_rd) begin
      cnt <= RD_LOAD;
    end else if (accept_wr) begin
      cnt <= WR_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      oor_q  <= 1'b0;
    end else if (accept_rd) begin
      addr_q <= i_m_addr[DEPTH_LOG2-1:0];
      oor_q  <= addr_oor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_m_readdata       <= '0;
      o_m_readdata_valid <= 1'b0;
    end else begin
      o_m_readdata_valid <= rd_done;
      if (rd_done) begin
        o_m_readdata <= oor_q ? FILL_PATTERN : bank_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_err <= 1'b0;
    end else if (idle && (i_m_read || i_m_write) && (addr_oor || (i_m_read && i_m_write))) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter READ_LAT, default 4, giving cycles from read acceptance to the data-valid pulse; legal range 1..15.
REQ-003 SHALL have parameter WRITE_LAT, default 2, giving busy cycles after write acceptance; legal range 0..15.
REQ-004 SHALL have clk, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have i_m_addr, input, 26 bits: word address from the cache memory-side master.
REQ-007 SHALL have i_m_byte_en, input, 4 bits: per-byte write enable; bit n covers data bits [8n+7:8n].
REQ-008 SHALL have i_m_writedata, input, 32 bits: write data.
REQ-009 SHALL have i_m_read, input, 1 bit: read command.
REQ-010 SHALL have i_m_write, input, 1 bit: write command.
REQ-011 SHALL have o_m_readdata, output, 32 bits: read data, qualified by o_m_readdata_valid.
REQ-012 SHALL have o_m_readdata_valid, output, 1 bit: one-cycle read-data strobe.
REQ-013 SHALL have o_m_waitrequest, output, 1 bit: high while the responder is busy.
REQ-014 SHALL have o_err, output, 1 bit: sticky protocol/range error flag.

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT; o_m_waitrequest = (state != IDLE), decoded from registered state only.
REQ-016 SHALL accept a command on a rising edge only when state is IDLE and i_m_read or i_m_write is high; commands while waitrequest is high are ignored and the master holds them.
REQ-017 On read acceptance at edge T: latch address, load down-counter with READ_LAT-1, enter RD_WAIT.
REQ-018 SHALL drive o_m_readdata_valid high for exactly one cycle, beginning at edge T+READ_LAT, with o_m_readdata = stored word; the same edge returns the FSM to IDLE, so waitrequest is high for cycles T..T+READ_LAT-1 after T.
REQ-019 o_m_readdata SHALL hold its last value between valid pulses.
REQ-020 On write acceptance at edge T: write enabled bytes into the array at edge T; if WRITE_LAT=0 remain IDLE, else enter WR_WAIT for WRITE_LAT cycles, then IDLE.
REQ-021 Write with i_m_byte_en=4'b0000 SHALL leave the array unchanged but keep identical timing.
REQ-022 i_m_read and i_m_write both high at acceptance: SHALL perform the write only, no read response, and set o_err.
REQ-023 Address >= 2**DEPTH_LOG2: write dropped, read returns 32'hDEADBEEF with normal timing; o_err set in both cases.
REQ-024 Down-counter width 4 bits; no wrap: counter saturates at 0 in IDLE.
REQ-025 o_err SHALL stay set until reset.

Reset
REQ-026 Reset asserted SHALL immediately force state IDLE, counter 0, o_m_readdata 32'h0, o_m_readdata_valid 0, o_err 0, o_m_waitrequest 0.
REQ-027 Reset mid-operation SHALL abandon the pending read with no valid pulse; writes already committed remain.
REQ-028 The storage array SHALL NOT be reset; contents are undefined until written.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state enum, default latency constants and the 32'hDEADBEEF fill pattern.
REQ-030 Storage SHALL be a sub-module dmem_bank: synchronous byte-enabled single-port RAM, combinational-address registered read.
REQ-031 FSM, counter and error logic SHALL live in dmem_responder.

Verification
REQ-032 Read word 0x10 after writing 32'h12345678 with byte_en=4'hF -> valid pulse 4 cycles after acceptance, data 32'h12345678, waitrequest high exactly 4 cycles.
REQ-033 Write 32'hAABBCCDD byte_en=4'b0101 over 32'h11223344 at 0x20, then read -> 32'h11BB33DD; waitrequest high 2 cycles after write.
REQ-034 Read and write high together at 0x30 -> write performed, no valid pulse, o_err=1 and stays 1.
REQ-035 Read address 26'h0400 (DEPTH_LOG2=10) -> 32'hDEADBEEF with normal latency, o_err=1.
REQ-036 Assert rst two cycles into a read -> no valid pulse, waitrequest 0 immediately; a subsequent read of a prior write returns the written data.
REQ-037 Back-to-back reads held by the master during waitrequest -> each accepted in the first IDLE cycle, one valid pulse per read, none lost or duplicated.
